// File: rtl/ds_pkg.sv
// Shared definitions for the dataset path (serial loader and row streamer).
// Holds the RAM geometry, the streamer state encoding and the helper that
// locates the first feature lane inside a row.
package ds_pkg;

   localparam int FIELD_W    = 16;
   localparam int NUM_LANES  = 16;
   localparam int DATA_WIDTH = FIELD_W * NUM_LANES;
   localparam int ADDR_WIDTH = 12;
   localparam int EPOCH_W    = 8;
   localparam int LANE_W     = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      STREAM,
      DONE
   } state_t;

   // Features are packed against the label, so x_0 sits feat lanes below
   // lane 15 and the label always lives in the top lane.
   function automatic logic [LANE_W-1:0] lane_base(input logic [LANE_W-1:0] feat);
      return LANE_W'(NUM_LANES - 1) - feat;
   endfunction

endpackage

// File: rtl/dataset_row_streamer_row_lane_mux.sv
// row_lane_mux: combinational 16:1 selector that picks one FIELD_W-bit lane
// out of a buffered RAM row.
// Ports:
//   row   - full buffered row, lane L in bits [16L+15:16L]
//   lane  - lane index to present
//   field - selected lane contents
module row_lane_mux
   import ds_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] row,
   input  logic [LANE_W-1:0]     lane,
   output logic [FIELD_W-1:0]    field
);

   // Plain decode loop; synthesises to a balanced mux tree.
   always_comb begin
      field = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane == LANE_W'(i)) begin
            field = row[i*FIELD_W +: FIELD_W];
         end
      end
   end

endmodule

// File: rtl/dataset_row_streamer.sv
// dataset_row_streamer: reads rows 0..num_dp from the dataset RAM, unpacks
// each row into 16-bit fields and streams x_0..x_(feat-1) then y over a
// valid/ready handshake, replaying the dataset for a programmable number of
// epochs.
// Ports:
//   CLK, RST        - clock, synchronous active-high reset
//   start           - begin a run (honoured only in IDLE or DONE)
//   num_dp          - index of the last row to stream
//   feat            - features per row (0..15)
//   epochs          - number of full passes (0 finishes immediately)
//   mem_en/mem_addr - RAM read request, data returns one cycle later
//   mem_rdata       - RAM read data
//   m_data/m_valid/m_ready - field stream to the training datapath
//   m_is_y          - current beat is the label
//   m_last_row      - current beat belongs to row num_dp
//   m_last_epoch    - current beat belongs to the final epoch
//   busy, done      - run status; done holds until the next start or RST
module dataset_row_streamer
   import ds_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] num_dp,
   input  logic [LANE_W-1:0]     feat,
   input  logic [EPOCH_W-1:0]    epochs,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [FIELD_W-1:0]    m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_is_y,
   output logic                  m_last_row,
   output logic                  m_last_epoch,
   output logic                  busy,
   output logic                  done
);

   localparam logic [LANE_W-1:0] LABEL_LANE = LANE_W'(NUM_LANES - 1);

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   row;
   logic [EPOCH_W:0]        epoch;
   logic [LANE_W-1:0]       lane;
   logic [DATA_WIDTH-1:0]   row_buf;
   logic [ADDR_WIDTH-1:0]   num_dp_q;
   logic [LANE_W-1:0]       feat_q;
   logic [EPOCH_W-1:0]      epochs_q;
   logic [FIELD_W-1:0]      lane_field;

   logic streaming;
   logic y_xfer;
   logic last_row_hit;
   logic last_epoch_hit;
   logic more_epochs;

   row_lane_mux u_mux (
      .row   (row_buf),
      .lane  (lane),
      .field (lane_field)
   );

   assign streaming      = (state == STREAM);
   assign y_xfer         = streaming && m_ready && (lane == LABEL_LANE);
   assign last_row_hit   = (row == num_dp_q);
   // epoch is one bit wider than epochs so a count of 255 cannot wrap.
   assign last_epoch_hit = (epoch == {1'b0, epochs_q});
   assign more_epochs    = (epoch < {1'b0, epochs_q});

   // State register plus the row/epoch/lane counters and latched run setup.
   // Configuration is captured only on an accepted start so that inputs may
   // change freely during a run.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         row      <= '0;
         epoch    <= '0;
         lane     <= '0;
         row_buf  <= '0;
         num_dp_q <= '0;
         feat_q   <= '0;
         epochs_q <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  num_dp_q <= num_dp;
                  feat_q   <= feat;
                  epochs_q <= epochs;
                  row      <= '0;
                  epoch    <= (EPOCH_W+1)'(1);
               end
            end
            WAIT: begin
               row_buf <= mem_rdata;
               lane    <= lane_base(feat_q);
            end
            STREAM: begin
               if (m_ready) begin
                  if (lane == LABEL_LANE) begin
                     if (!last_row_hit) begin
                        row <= row + 1'b1;
                     end else if (more_epochs) begin
                        row   <= '0;
                        epoch <= epoch + 1'b1;
                     end
                  end else begin
                     lane <= lane + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic: one FETCH/WAIT bubble pair per row, then feat+1 beats.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = (epochs == '0) ? DONE : FETCH;
            end
         end
         FETCH:  state_next = WAIT;
         WAIT:   state_next = STREAM;
         STREAM: begin
            if (y_xfer) begin
               state_next = (last_row_hit && !more_epochs) ? DONE : FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode from registered state only, so they cannot move while
   // the consumer is stalling a beat.
   always_comb begin
      mem_en       = (state == FETCH);
      mem_addr     = row;
      m_valid      = streaming;
      m_data       = streaming ? lane_field : '0;
      m_is_y       = streaming && (lane == LABEL_LANE);
      m_last_row   = streaming && last_row_hit;
      m_last_epoch = streaming && last_epoch_hit;
      busy         = (state == FETCH) || (state == WAIT) || streaming;
      done         = (state == DONE);
   end

endmodule
